// File: rtl/ingress_port_packer_pkg.sv
// Shared types for the ingress port packer: storage line layout, packer FSM states
// and bus word helpers.
package ingress_pkg;

  localparam int LINE_BYTES = 16;

  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   bytes;
    logic         last;
  } line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    DISCARD = 2'd2
  } packer_state_t;

  // bytes_valid 1..3 marks a partial word; every other code carries a full word.
  function automatic logic [4:0] word_bytes(input logic [2:0] bv);
    return (bv inside {3'd1, 3'd2, 3'd3}) ? {2'b00, bv} : 5'd4;
  endfunction

  function automatic logic [31:0] justify_word(input logic [31:0] d, input logic [2:0] bv);
    case (bv)
      3'd1:    return {d[31:24], 24'h0};
      3'd2:    return {d[31:16], 16'h0};
      3'd3:    return {d[31:8], 8'h0};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/ingress_port_packer_if.sv
// EthernetRxBus as seen by the packer: one word per cycle plus frame framing strobes.
interface ingress_port_packer_if;
  logic        start;
  logic        data_valid;
  logic [2:0]  bytes_valid;
  logic [31:0] data;
  logic        commit;
  logic        drop;

  modport master (output start, data_valid, bytes_valid, data, commit, drop);
  modport slave  (input  start, data_valid, bytes_valid, data, commit, drop);
endinterface

// File: rtl/ingress_port_packer_line_ram.sv
// Simple dual-port line store: one write and one registered read per rx_clk.
module ingress_line_ram
  import ingress_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  line_t                    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output line_t                    rdata
);

  line_t mem [DEPTH];
  line_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ingress_port_packer.sv
// Per-port ingress front end: packs 32-bit RX words into 128-bit lines, stores frames
// speculatively and releases only committed frames on a valid/ready line stream.
module ingress_port_packer
  import ingress_pkg::*;
#(
  parameter int LINE_DEPTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         rx_clk,
  input  logic                         rst_n,
  input  logic                         link_up,
  ingress_port_packer_if.slave         rx_bus,
  // Stream: a line transfers on a cycle where out_valid & out_ready are both high;
  // while out_valid is high and out_ready low, out_data/out_bytes/out_last hold.
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [127:0]                 out_data,
  output logic [4:0]                   out_bytes,
  output logic                         out_last,
  output logic [CNT_WIDTH-1:0]         frame_count,
  output logic [CNT_WIDTH-1:0]         drop_count,
  output packer_state_t                dbg_state,
  output logic [$clog2(LINE_DEPTH):0]  dbg_wr_ptr,
  output logic [$clog2(LINE_DEPTH):0]  dbg_cm_ptr
);

  localparam int AW = $clog2(LINE_DEPTH);
  typedef logic [AW:0] ptr_t;

  packer_state_t        state_q, state_d;
  logic [127:0]         acc_data_q, acc_data_d;
  logic [4:0]           acc_bytes_q, acc_bytes_d;
  logic                 acc_partial_q, acc_partial_d;
  logic                 commit_pend_q, commit_pend_d;
  ptr_t                 wr_ptr_q, wr_ptr_d;
  ptr_t                 cm_ptr_q, cm_ptr_d;
  ptr_t                 rd_ptr_q, rd_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;

  logic        wr_en, do_commit, do_discard, do_restart, full, pop;
  line_t       wr_line, rd_line;
  logic [4:0]  wbytes;
  logic [31:0] wdata;

  assign full = (wr_ptr_q - rd_ptr_q) == ptr_t'(LINE_DEPTH);
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d       = state_q;
    acc_data_d    = acc_data_q;
    acc_bytes_d   = acc_bytes_q;
    acc_partial_d = acc_partial_q;
    commit_pend_d = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    cm_ptr_d      = cm_ptr_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    wr_en         = 1'b0;
    wr_line       = '0;
    do_commit     = 1'b0;
    do_discard    = 1'b0;
    do_restart    = 1'b0;
    wbytes        = word_bytes(rx_bus.bytes_valid);
    wdata         = justify_word(rx_bus.data, rx_bus.bytes_valid);

    case (state_q)
      IDLE: begin
        // A start cycle only opens the frame; its data lane is not sampled.
        if (rx_bus.start && link_up) begin
          state_d       = ACTIVE;
          acc_data_d    = '0;
          acc_bytes_d   = '0;
          acc_partial_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (commit_pend_q) begin
          // Second half of a word+commit that also flushed a held-back full line.
          if (full) do_discard = 1'b1;
          else begin
            wr_en     = 1'b1;
            wr_line   = '{data: acc_data_q, bytes: acc_bytes_q, last: 1'b1};
            do_commit = 1'b1;
          end
        end else if (!link_up || rx_bus.drop) begin
          do_discard = 1'b1;
        end else if (rx_bus.start) begin
          do_discard = 1'b1;
          do_restart = 1'b1;
        end else if (rx_bus.data_valid) begin
          if (acc_partial_q || (acc_bytes_q == 5'(LINE_BYTES) && full)) begin
            if (rx_bus.commit) do_discard = 1'b1;
            else               state_d    = DISCARD;
          end else begin
            if (acc_bytes_q == 5'(LINE_BYTES)) begin
              wr_en       = 1'b1;
              wr_line     = '{data: acc_data_q, bytes: acc_bytes_q, last: 1'b0};
              acc_data_d  = {wdata, 96'h0};
              acc_bytes_d = wbytes;
            end else begin
              case (acc_bytes_q[3:2])
                2'd0:    acc_data_d[127:96] = wdata;
                2'd1:    acc_data_d[95:64]  = wdata;
                2'd2:    acc_data_d[63:32]  = wdata;
                default: acc_data_d[31:0]   = wdata;
              endcase
              acc_bytes_d = acc_bytes_q + wbytes;
            end
            acc_partial_d = (wbytes != 5'd4);
            if (rx_bus.commit) begin
              if (wr_en) commit_pend_d = 1'b1;
              else if (full) do_discard = 1'b1;
              else begin
                wr_en     = 1'b1;
                wr_line   = '{data: acc_data_d, bytes: acc_bytes_d, last: 1'b1};
                do_commit = 1'b1;
              end
            end
          end
        end else if (rx_bus.commit) begin
          if (acc_bytes_q == 5'd0 || full) do_discard = 1'b1;
          else begin
            wr_en     = 1'b1;
            wr_line   = '{data: acc_data_q, bytes: acc_bytes_q, last: 1'b1};
            do_commit = 1'b1;
          end
        end
      end
      DISCARD: begin
        if (!link_up || rx_bus.drop || rx_bus.commit) do_discard = 1'b1;
        else if (rx_bus.start) begin
          do_discard = 1'b1;
          do_restart = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (do_commit) begin
      cm_ptr_d      = wr_ptr_d;
      frame_count_d = frame_count_q + 1'b1;
      state_d       = IDLE;
    end
    if (do_discard) begin
      wr_ptr_d      = cm_ptr_q;
      drop_count_d  = drop_count_q + 1'b1;
      state_d       = do_restart ? ACTIVE : IDLE;
      acc_data_d    = '0;
      acc_bytes_d   = '0;
      acc_partial_d = 1'b0;
      commit_pend_d = 1'b0;
    end
  end

  // Read side: the RAM re-reads the head line every cycle so the registered output
  // stays put under stall; old cm_ptr delays out_valid until the write has landed.
  always_comb begin
    rd_ptr_d    = rd_ptr_q + ptr_t'(pop);
    out_valid_d = (cm_ptr_q != rd_ptr_d);
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_data_q    <= '0;
      acc_bytes_q   <= '0;
      acc_partial_q <= 1'b0;
      commit_pend_q <= 1'b0;
      wr_ptr_q      <= '0;
      cm_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      acc_data_q    <= acc_data_d;
      acc_bytes_q   <= acc_bytes_d;
      acc_partial_q <= acc_partial_d;
      commit_pend_q <= commit_pend_d;
      wr_ptr_q      <= wr_ptr_d;
      cm_ptr_q      <= cm_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      out_valid_q   <= out_valid_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  ingress_line_ram #(.DEPTH(LINE_DEPTH)) u_line_ram (
    .clk   (rx_clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_line),
    .raddr (rd_ptr_d[AW-1:0]),
    .rdata (rd_line)
  );

  assign out_valid   = out_valid_q;
  assign out_data    = rd_line.data;
  assign out_bytes   = rd_line.bytes;
  assign out_last    = rd_line.last;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign dbg_state   = state_q;
  assign dbg_wr_ptr  = wr_ptr_q;
  assign dbg_cm_ptr  = cm_ptr_q;

endmodule

// File: tb/tb_ingress_port_packer.sv
// Directed bench for ingress_port_packer: hand-computed lines go into an expected
// queue, a negedge monitor pops and compares every line the DUT hands over.
module tb_ingress_port_packer;
  import ingress_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int PW    = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           link_up = 1'b1;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [127:0]   out_data;
  logic [4:0]     out_bytes;
  logic           out_last;
  logic [CW-1:0]  frame_count, drop_count;
  packer_state_t  dbg_state;
  logic [PW-1:0]  dbg_wr_ptr, dbg_cm_ptr;

  ingress_port_packer_if bus ();

  ingress_port_packer #(.LINE_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .rx_clk      (clk),
    .rst_n       (rst_n),
    .link_up     (link_up),
    .rx_bus      (bus),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_bytes   (out_bytes),
    .out_last    (out_last),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .dbg_state   (dbg_state),
    .dbg_wr_ptr  (dbg_wr_ptr),
    .dbg_cm_ptr  (dbg_cm_ptr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [133:0]  exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            pops = 0;
  int            ready_mode = 1;   // 0 hold low, 1 hold high, 2 toggle
  int            exp_frames = 0;
  int            exp_drops = 0;
  logic [PW-1:0] exp_cm = '0;

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] b);
    return {b, b + 32'd1, b + 32'd2, b + 32'd3};
  endfunction

  task automatic push_line(input logic [127:0] d, input logic [4:0] b, input logic l);
    exp_q.push_back({d, b, l});
  endtask

  // ---------------- ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ~out_ready;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_line: got %h expected no line", {out_data, out_bytes, out_last});
          if (out_ready) pops++;
        end else if (out_ready) begin
          check_line("line", {out_data, out_bytes, out_last}, exp_q.pop_front());
          pops++;
        end else begin
          check_line("stall_hold", {out_data, out_bytes, out_last}, exp_q[0]);
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic bus_cycle(input logic st, input logic dv, input logic [2:0] bv,
                           input logic [31:0] d, input logic cm, input logic dr);
    bus.start = st; bus.data_valid = dv; bus.bytes_valid = bv;
    bus.data = d; bus.commit = cm; bus.drop = dr;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.data_valid = 1'b0; bus.bytes_valid = 3'd0;
    bus.data = 32'h0; bus.commit = 1'b0; bus.drop = 1'b0;
  endtask

  task automatic start_frame();
    bus_cycle(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic word(input logic [31:0] d, input logic [2:0] bv, input logic cm);
    bus_cycle(1'b0, 1'b1, bv, d, cm, 1'b0);
  endtask

  task automatic commit_frame();
    bus_cycle(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic drop_frame();
    bus_cycle(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic end_checks(input string t);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: got %0d lines left expected 0", t, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    check_val({t, "_frame_count"}, int'(frame_count), exp_frames);
    check_val({t, "_drop_count"}, int'(drop_count), exp_drops);
    check_val({t, "_cm_ptr"}, int'(dbg_cm_ptr), int'(exp_cm));
    check_val({t, "_wr_ptr"}, int'(dbg_wr_ptr), int'(exp_cm));
    check_val({t, "_state"}, int'(dbg_state), int'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;
    bus.start = 1'b0; bus.data_valid = 1'b0; bus.bytes_valid = 3'd0;
    bus.data = 32'h0; bus.commit = 1'b0; bus.drop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", int'(out_valid), 0);
    check_line("rst_out_line", {out_data, out_bytes, out_last}, 134'h0);
    check_val("rst_frame_count", int'(frame_count), 0);
    check_val("rst_drop_count", int'(drop_count), 0);
    check_val("rst_state", int'(dbg_state), int'(IDLE));
    check_val("rst_wr_ptr", int'(dbg_wr_ptr), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: four full words plus a 3-byte partial word
    push_line({32'hFEEDFACE, 32'hDEADBEEF, 32'hCAFEF00D, 32'hBAADC0DE}, 5'd16, 1'b0);
    push_line({32'h41414100, 96'h0}, 5'd3, 1'b1);
    start_frame();
    word(32'hFEEDFACE, 3'd4, 1'b0);
    word(32'hDEADBEEF, 3'd4, 1'b0);
    word(32'hCAFEF00D, 3'd4, 1'b0);
    word(32'hBAADC0DE, 3'd4, 1'b0);
    word(32'h414141FF, 3'd3, 1'b0);
    commit_frame();
    exp_frames++; exp_cm = exp_cm + 3'd2;
    end_checks("t1");

    // 2: exactly two full lines, no trailing empty line
    push_line({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 5'd16, 1'b0);
    push_line({32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888}, 5'd16, 1'b1);
    start_frame();
    for (int i = 1; i <= 8; i++) word(32'(32'h11111111 * i), 3'd4, 1'b0);
    commit_frame();
    exp_frames++; exp_cm = exp_cm + 3'd2;
    end_checks("t2");

    // 3: dropped frame, then a single-word frame
    start_frame();
    word(32'hAAAA0001, 3'd4, 1'b0);
    word(32'hAAAA0002, 3'd4, 1'b0);
    word(32'hAAAA0003, 3'd4, 1'b0);
    drop_frame();
    exp_drops++;
    check_val("t3_rollback_wr", int'(dbg_wr_ptr), int'(exp_cm));
    push_line({32'h12345678, 96'h0}, 5'd4, 1'b1);
    start_frame();
    word(32'h12345678, 3'd4, 1'b0);
    commit_frame();
    exp_frames++; exp_cm = exp_cm + 3'd1;
    end_checks("t3");

    // 5: restart mid-frame
    push_line({32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 32'hA4A4A4A4}, 5'd16, 1'b1);
    start_frame();
    word(32'h0BAD0001, 3'd4, 1'b0);
    word(32'h0BAD0002, 3'd4, 1'b0);
    start_frame();
    word(32'hA1A1A1A1, 3'd4, 1'b0);
    word(32'hA2A2A2A2, 3'd4, 1'b0);
    word(32'hA3A3A3A3, 3'd4, 1'b0);
    word(32'hA4A4A4A4, 3'd4, 1'b0);
    commit_frame();
    exp_drops++; exp_frames++; exp_cm = exp_cm + 3'd1;
    end_checks("t5");

    // 7: commit on the fifth word flushes the held line and the new word
    push_line(mk_line(32'h70000001), 5'd16, 1'b0);
    push_line({32'h70000005, 96'h0}, 5'd4, 1'b1);
    start_frame();
    for (int i = 1; i <= 4; i++) word(32'h70000000 + 32'(i), 3'd4, 1'b0);
    word(32'h70000005, 3'd4, 1'b1);
    exp_frames++; exp_cm = exp_cm + 3'd2;
    end_checks("t7");

    // 8: protocol error, empty commit, link loss
    start_frame();
    word(32'h01020000, 3'd2, 1'b0);
    word(32'h03040506, 3'd4, 1'b0);
    check_val("t8_discard_state", int'(dbg_state), int'(DISCARD));
    commit_frame();
    start_frame();
    commit_frame();
    start_frame();
    word(32'h0F0F0F0F, 3'd4, 1'b0);
    link_up = 1'b0;
    bus_cycle(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    link_up = 1'b1;
    exp_drops += 3;
    end_checks("t8");

    // 4: overflow with consumer stalled, then a small frame alone emerges
    ready_mode = 0;
    start_frame();
    for (int i = 1; i <= 20; i++) word(32'h40000000 + 32'(i), 3'd4, 1'b0);
    commit_frame();
    exp_drops++;
    repeat (4) @(posedge clk);
    #1;
    check_val("t4_no_output", int'(out_valid), 0);
    ready_mode = 1;
    push_line({32'hAAAAAAAA, 32'hBBBBBBBB, 64'h0}, 5'd8, 1'b1);
    start_frame();
    word(32'hAAAAAAAA, 3'd4, 1'b0);
    word(32'hBBBBBBBB, 3'd4, 1'b0);
    commit_frame();
    exp_frames++; exp_cm = exp_cm + 3'd1;
    end_checks("t4");

    // 6: two frames under a toggling consumer, then reset while lines remain
    ready_mode = 2;
    base = pops;
    push_line(mk_line(32'hA0000001), 5'd16, 1'b0);
    push_line(mk_line(32'hA0000005), 5'd16, 1'b1);
    push_line(mk_line(32'hB0000001), 5'd16, 1'b0);
    push_line(mk_line(32'hB0000005), 5'd16, 1'b1);
    start_frame();
    for (int i = 1; i <= 8; i++) word(32'hA0000000 + 32'(i), 3'd4, 1'b0);
    commit_frame();
    start_frame();
    for (int i = 1; i <= 8; i++) word(32'hB0000000 + 32'(i), 3'd4, 1'b0);
    commit_frame();
    n = 0;
    while (pops < base + 3 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check_val("t6_pops_before_reset", pops - base, 3);
    #2;
    check_val("t6_valid_before_reset", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_out_valid", int'(out_valid), 0);
    check_val("t6_rst_frame_count", int'(frame_count), 0);
    check_val("t6_rst_drop_count", int'(drop_count), 0);
    check_val("t6_rst_cm_ptr", int'(dbg_cm_ptr), 0);
    exp_q.delete();
    exp_frames = 0; exp_drops = 0; exp_cm = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;
    push_line({32'hC0FFEE11, 96'h0}, 5'd4, 1'b1);
    start_frame();
    word(32'hC0FFEE11, 3'd4, 1'b0);
    commit_frame();
    exp_frames++; exp_cm = exp_cm + 3'd1;
    end_checks("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
